// File: rtl/arbitro_vram_pkg.sv
// Shared constants and grant-owner encoding for the VRAM arbiter.
package arbitro_vram_pkg;

   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_H     = 120;
   localparam int unsigned FB_SIZE  = FB_W * FB_H;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned DATA_W   = 3;
   localparam int unsigned PIPE_LAT = 2;

   // Owner of the single RAM port in the current cycle
   typedef enum logic [1:0] {
      NONE    = 2'd0,
      DISPLAY = 2'd1,
      WRITER  = 2'd2,
      READER  = 2'd3
   } owner_t;

endpackage

// File: rtl/arbitro_vram_calc_dir_pixel.sv
// Screen coordinate to framebuffer address: (y>>2)*160 + (x>>2) using shift-add only.
module calc_dir_pixel (
   input  logic [9:0]                          pixel_x,
   input  logic [9:0]                          pixel_y,
   output logic [arbitro_vram_pkg::ADDR_W-1:0] pix_addr
);
   import arbitro_vram_pkg::*;

   logic [ADDR_W-1:0] cell_x;
   logic [ADDR_W-1:0] cell_y;
   logic              unused_low_bits;

   // Drop the two LSBs: each framebuffer cell covers a 4x4 screen block
   assign cell_x          = ADDR_W'(pixel_x[9:2]);
   assign cell_y          = ADDR_W'(pixel_y[9:2]);
   assign unused_low_bits = ^{pixel_x[1:0], pixel_y[1:0]};

   // y*160 = y*128 + y*32, wraps at 15 bits
   assign pix_addr = (cell_y << 7) + (cell_y << 5) + cell_x;

endmodule

// File: rtl/arbitro_vram.sv
// Single-port VRAM arbiter: display has absolute priority while video_on,
// writer and reader share blanking time round-robin.
module arbitro_vram #(
   parameter int unsigned DATA_W = arbitro_vram_pkg::DATA_W,
   parameter int unsigned FB_W   = arbitro_vram_pkg::FB_W,
   parameter int unsigned FB_H   = arbitro_vram_pkg::FB_H
) (
   input  logic                                CLK_pix_rate,
   input  logic                                reset,
   input  logic                                video_on,
   input  logic                                h_sync_in,
   input  logic                                v_sync_in,
   input  logic [9:0]                          pixel_x,
   input  logic [9:0]                          pixel_y,
   input  logic                                wr_req,
   input  logic [arbitro_vram_pkg::ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]                   wr_data,
   output logic                                wr_ack,
   input  logic                                rd_req,
   input  logic [arbitro_vram_pkg::ADDR_W-1:0] rd_addr,
   output logic                                rd_ack,
   output logic                                rd_valid,
   output logic [DATA_W-1:0]                   rd_data,
   output logic [arbitro_vram_pkg::ADDR_W-1:0] ram_addr,
   output logic                                ram_we,
   output logic [DATA_W-1:0]                   ram_wdata,
   input  logic [DATA_W-1:0]                   ram_rdata,
   output logic [DATA_W-1:0]                   rgb,
   output logic                                h_sync,
   output logic                                v_sync,
   output logic                                video_on_out
);
   import arbitro_vram_pkg::*;

   localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_W * FB_H);

   owner_t              owner;
   owner_t              last_grant;
   logic [ADDR_W-1:0]   disp_addr;
   logic                rd_inrange;
   logic [PIPE_LAT-1:0] hs_pipe;
   logic [PIPE_LAT-1:0] vs_pipe;
   logic [PIPE_LAT-1:0] von_pipe;

   calc_dir_pixel u_calc_dir_pixel (
      .pixel_x  (pixel_x),
      .pixel_y  (pixel_y),
      .pix_addr (disp_addr)
   );

   // Pick this cycle's RAM owner; nobody owns the port while reset is held
   always_comb begin
      owner = NONE;
      if (!reset)
         owner = NONE;
      else if (video_on)
         owner = DISPLAY;
      else if (wr_req && rd_req)
         owner = (last_grant == READER) ? WRITER : READER;
      else if (wr_req)
         owner = WRITER;
      else if (rd_req)
         owner = READER;
   end

   // Drive the RAM port and acks from the current grant
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      wr_ack    = 1'b0;
      rd_ack    = 1'b0;
      case (owner)
         DISPLAY: ram_addr = disp_addr;
         WRITER: begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            ram_we    = (wr_addr < FB_LIMIT);
            wr_ack    = 1'b1;
         end
         READER: begin
            ram_addr = rd_addr;
            rd_ack   = 1'b1;
         end
         default: ;
      endcase
   end

   // Round-robin memory: only real requester grants move it
   always_ff @(posedge CLK_pix_rate or negedge reset) begin
      if (!reset)
         last_grant <= READER;
      else if (owner == WRITER || owner == READER)
         last_grant <= owner;
   end

   // Read response flags, aligned with ram_rdata one cycle after the grant
   always_ff @(posedge CLK_pix_rate or negedge reset) begin
      if (!reset) begin
         rd_valid   <= 1'b0;
         rd_inrange <= 1'b0;
      end else begin
         rd_valid   <= (owner == READER);
         rd_inrange <= (rd_addr < FB_LIMIT);
      end
   end

   // Out-of-range reads return zero instead of whatever the RAM holds
   assign rd_data = (rd_valid && rd_inrange) ? ram_rdata : '0;

   // Sync/video_on delay line matching the RAM read plus rgb register
   always_ff @(posedge CLK_pix_rate or negedge reset) begin
      if (!reset) begin
         hs_pipe  <= '1;
         vs_pipe  <= '1;
         von_pipe <= '0;
      end else begin
         hs_pipe  <= {hs_pipe[PIPE_LAT-2:0], h_sync_in};
         vs_pipe  <= {vs_pipe[PIPE_LAT-2:0], v_sync_in};
         von_pipe <= {von_pipe[PIPE_LAT-2:0], video_on};
      end
   end

   // Capture display data, blanked outside the active area
   always_ff @(posedge CLK_pix_rate or negedge reset) begin
      if (!reset)
         rgb <= '0;
      else
         rgb <= von_pipe[0] ? ram_rdata : '0;
   end

   assign h_sync       = hs_pipe[PIPE_LAT-1];
   assign v_sync       = vs_pipe[PIPE_LAT-1];
   assign video_on_out = von_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_arbitro_vram.sv
// Scoreboard bench for arbitro_vram with a behavioural framebuffer model.
module tb_arbitro_vram;

   localparam int FB_W  = 160;
   localparam int FB_SZ = 19200;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        video_on = 1'b0, h_sync_in = 1'b1, v_sync_in = 1'b1;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        wr_req = 1'b0, rd_req = 1'b0;
   logic [14:0] wr_addr = '0, rd_addr = '0;
   logic [2:0]  wr_data = '0;
   logic        wr_ack, rd_ack, rd_valid, ram_we, h_sync, v_sync, video_on_out;
   logic [2:0]  rd_data, ram_wdata, ram_rdata, rgb;
   logic [14:0] ram_addr;

   arbitro_vram dut (
      .CLK_pix_rate(clk), .reset(reset), .video_on(video_on), .h_sync_in(h_sync_in),
      .v_sync_in(v_sync_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .rd_req(rd_req),
      .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync), .video_on_out(video_on_out)
   );

   always #5 clk = ~clk;

   // Environment RAM: synchronous, read-first, 1-cycle latency, full 15-bit space
   logic [2:0] mem [32768];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Reference framebuffer contents as the specification sees them
   logic [2:0] fb [FB_SZ];
   bit m_last_rd;
   bit m_rd_prev;

   typedef struct { bit wr_ack; bit rd_ack; bit we; bit chk_addr; bit rd_valid; int addr; int wdata; } cyc_t;
   typedef struct { int rgb; bit hs; bit vs; bit von; } pix_t;
   cyc_t exp_cyc[$];
   int   exp_rd[$];
   pix_t exp_pix[$];

   int n_chk = 0, n_fail = 0;
   bit mon_en = 1'b0;
   bit s_wr_ack, s_rd_ack, s_we, s_rd_valid, s_hs;
   int s_addr, s_rd_data, s_rgb;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the queued expectations
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_cyc.size() == 0) chk("cyc_queue_underflow", 0, 1);
         else begin
            cyc_t e;
            e = exp_cyc.pop_front();
            chk("wr_ack", int'(wr_ack), int'(e.wr_ack));
            chk("rd_ack", int'(rd_ack), int'(e.rd_ack));
            chk("ram_we", int'(ram_we), int'(e.we));
            chk("rd_valid", int'(rd_valid), int'(e.rd_valid));
            if (e.chk_addr) chk("ram_addr", int'(ram_addr), e.addr);
            if (e.we) chk("ram_wdata", int'(ram_wdata), e.wdata);
         end
         if (rd_valid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", int'(rd_data), exp_rd.pop_front());
         end
         if (exp_pix.size() == 0) chk("pix_queue_underflow", 0, 1);
         else begin
            pix_t p;
            p = exp_pix.pop_front();
            chk("rgb", int'(rgb), p.rgb);
            chk("h_sync", int'(h_sync), int'(p.hs));
            chk("v_sync", int'(v_sync), int'(p.vs));
            chk("video_on_out", int'(video_on_out), int'(p.von));
         end
      end
   end

   // One pixel clock of stimulus; the model predicts grants and pushes expectations
   task automatic cycle(input bit von, input int px, input int py, input bit hs, input bit vs,
                        input bit wq, input int wa, input int wd, input bit rq, input int ra,
                        output bit g_w, output bit g_r);
      cyc_t e;
      pix_t p;
      video_on = von; pixel_x = 10'(px); pixel_y = 10'(py);
      h_sync_in = hs; v_sync_in = vs;
      wr_req = wq; wr_addr = 15'(wa); wr_data = 3'(wd);
      rd_req = rq; rd_addr = 15'(ra);
      e = '{default: 0};
      g_w = 1'b0; g_r = 1'b0;
      p.rgb = 0; p.hs = hs; p.vs = vs; p.von = von;
      if (von) begin
         e.addr = (py / 4) * FB_W + px / 4;
         e.chk_addr = 1'b1;
         p.rgb = int'(fb[e.addr]);
      end else if (wq && rq) begin
         if (m_last_rd) g_w = 1'b1; else g_r = 1'b1;
      end else if (wq) g_w = 1'b1;
      else if (rq) g_r = 1'b1;
      if (g_w) begin
         m_last_rd = 1'b0;
         e.wr_ack = 1'b1; e.chk_addr = 1'b1; e.addr = wa; e.wdata = wd;
         e.we = (wa < FB_SZ);
         if (e.we) fb[wa] = 3'(wd);
      end
      if (g_r) begin
         m_last_rd = 1'b1;
         e.rd_ack = 1'b1; e.chk_addr = 1'b1; e.addr = ra;
         exp_rd.push_back((ra < FB_SZ) ? int'(fb[ra]) : 0);
      end
      e.rd_valid = m_rd_prev;
      m_rd_prev = g_r;
      exp_cyc.push_back(e);
      exp_pix.push_back(p);
      @(negedge clk);
      s_wr_ack = wr_ack; s_rd_ack = rd_ack; s_we = ram_we; s_addr = int'(ram_addr);
      s_rd_valid = rd_valid; s_rd_data = int'(rd_data); s_rgb = int'(rgb); s_hs = h_sync;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bit gw, gr;
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, gw, gr);
   endtask

   // Assert reset, check cleared outputs at once, then release and restart the model
   task automatic do_reset();
      pix_t r;
      reset = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("rst_wr_ack", int'(wr_ack), 0);
      chk("rst_rd_ack", int'(rd_ack), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_video_on_out", int'(video_on_out), 0);
      chk("rst_h_sync", int'(h_sync), 1);
      chk("rst_v_sync", int'(v_sync), 1);
      exp_cyc.delete(); exp_rd.delete(); exp_pix.delete();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      m_last_rd = 1'b1;
      m_rd_prev = 1'b0;
      r.rgb = 0; r.hs = 1'b1; r.vs = 1'b1; r.von = 1'b0;
      exp_pix.push_back(r);
      exp_pix.push_back(r);
      mon_en = 1'b1;
   endtask

   initial begin
      bit gw, gr, wp, rp, von;
      int wa, wd, ra, nw, nr;
      for (int i = 0; i < 32768; i++) begin
         mem[i] = 3'($urandom_range(0, 7));
         if (i < FB_SZ) fb[i] = mem[i];
      end
      mem[20000] = 3'b111;
      #2;
      do_reset();

      // Single write then read-back of the same address
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 100, 5, 1'b0, 0, gw, gr);
      chk("w100_ack", int'(s_wr_ack), 1);
      chk("w100_we", int'(s_we), 1);
      chk("w100_addr", s_addr, 100);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 100, gw, gr);
      chk("r100_ack", int'(s_rd_ack), 1);
      idle(1);
      chk("r100_valid", int'(s_rd_valid), 1);
      chk("r100_data", s_rd_data, 5);

      // Both requesters held for four cycles alternate W,R,W,R
      nw = 0; nr = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 200 + i, i, 1'b1, 300 + i, gw, gr);
         chk("rr_order", int'(s_wr_ack), (i % 2 == 0) ? 1 : 0);
         nw += int'(s_wr_ack); nr += int'(s_rd_ack);
      end
      chk("rr_wr_count", nw, 2);
      chk("rr_rd_count", nr, 2);

      // Display fetch of pixel (8,4) -> cell 162, rgb two cycles later
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 162, 6, 1'b0, 0, gw, gr);
      cycle(1'b1, 8, 4, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 50, gw, gr);
      chk("disp_addr", s_addr, 162);
      chk("disp_no_rd_ack", int'(s_rd_ack), 0);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 50, gw, gr);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, gw, gr);
      chk("disp_rgb", s_rgb, 6);
      chk("disp_hsync_delay", int'(s_hs), 0);

      // Write raised on last blanking cycle and held through a 640-pixel active line
      nw = 0;
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 777, 3, 1'b0, 0, gw, gr);
      nw += int'(s_wr_ack);
      for (int i = 0; i < 640; i++) begin
         cycle(1'b1, i, 8, 1'b1, 1'b1, 1'b1, 777, 3, 1'b0, 0, gw, gr);
         nw += int'(s_wr_ack);
      end
      chk("line_wr_acks", nw, 1);

      // Out-of-range addresses
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 19200, 7, 1'b0, 0, gw, gr);
      chk("oob_wr_ack", int'(s_wr_ack), 1);
      chk("oob_we", int'(s_we), 0);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 20000, gw, gr);
      idle(1);
      chk("oob_rd_valid", int'(s_rd_valid), 1);
      chk("oob_rd_data", s_rd_data, 0);

      // Random traffic with video_on bursts and a reset in the middle
      wp = 1'b0; rp = 1'b0; von = 1'b0; wa = 0; wd = 0; ra = 0;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) do_reset();
         if ($urandom_range(0, 15) == 0) von = !von;
         if (!wp && $urandom_range(0, 2) == 0) begin
            wp = 1'b1;
            wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19200, 32767)) : int'($urandom_range(0, 19199));
            wd = int'($urandom_range(0, 7));
         end
         if (!rp && $urandom_range(0, 2) == 0) begin
            rp = 1'b1;
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19200, 32767)) : int'($urandom_range(0, 19199));
         end
         cycle(von, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wp, wa, wd, rp, ra, gw, gr);
         if (gw) wp = 1'b0;
         if (gr) rp = 1'b0;
      end
      idle(3);

      // Reset while a read response and a display pixel are on the outputs
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 162, 6, 1'b0, 0, gw, gr);
      cycle(1'b1, 8, 4, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, gw, gr);
      cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 162, gw, gr);
      do_reset();
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 400, 2, 1'b1, 401, gw, gr);
      chk("post_rst_wr_first", int'(s_wr_ack), 1);
      chk("post_rst_no_rd", int'(s_rd_ack), 0);
      idle(3);

      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("cyc_queue_drained", exp_cyc.size(), 0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
